// File: rtl/imem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory among N_REQ fetch ports.
// One address reaches the memory per cycle; the returned word is registered with a one-hot valid pulse.
module imem_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      RESET_N,
    input  logic                      clear,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    output logic                      im_read,
    output logic [ADDR_W-1:0]         im_addr,
    input  logic [DATA_W-1:0]         im_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t              ptr_q, ptr_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;

    logic [N_REQ-1:0]  elig;
    logic              found;
    ptr_t              win;

    // (base + k) mod N_REQ for k < N_REQ, without a divider.
    function automatic ptr_t wrap_add(input ptr_t base, input int k);
        int s;
        s = int'(base) + k;
        return (s >= N_REQ) ? ptr_t'(s - N_REQ) : ptr_t'(s);
    endfunction

    // A core whose data is being returned this cycle is not eligible, so a held
    // req cannot be granted twice for the same fetch.
    assign elig = req & ~rvalid_q;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        if (RESET_N && !clear) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && elig[wrap_add(ptr_q, k)]) begin
                    found = 1'b1;
                    win   = wrap_add(ptr_q, k);
                end
            end
        end
        gnt     = found ? (N_REQ'(1) << win) : '0;
        im_read = found;
        im_addr = found ? addr[win*ADDR_W +: ADDR_W] : '0;
    end

    always_comb begin
        ptr_d    = ptr_q;
        rdata_d  = rdata_q;
        rvalid_d = gnt;
        busy_d   = found;
        if (clear) begin
            ptr_d    = '0;
            rvalid_d = '0;
            busy_d   = 1'b0;
        end else if (found) begin
            rdata_d = im_data;
            ptr_d   = wrap_add(win, 1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_imem_rr_arbiter.sv
// Directed and randomized checks of imem_rr_arbiter against a behavioural model
// that tracks the round-robin pointer, the data owner and the last returned word.
module tb_imem_rr_arbiter;

    localparam int N = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk;
    logic            RESET_N;
    logic            clear;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic            im_read;
    logic [AW-1:0]   im_addr;
    logic [DW-1:0]   im_data;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;

    logic [DW-1:0]   mem [256];
    assign im_data = mem[im_addr[7:0]];

    imem_rr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .RESET_N(RESET_N), .clear(clear), .req(req), .addr(addr),
        .im_read(im_read), .im_addr(im_addr), .im_data(im_data),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: next search start, core owning the registered word (-1 = none), that word.
    int          m_ptr;
    int          m_owner;
    logic [15:0] m_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr, input int owner);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (r[i] && i != owner) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_owner = -1;
        m_rdata = '0;
    endtask

    // One clock cycle: drive at the falling edge, check mid-low phase, update the model at the rising edge.
    task automatic cycle(input logic [N-1:0] r, input logic c, input string tag, output logic [N-1:0] g_obs);
        int w;
        logic [N-1:0] exp_gnt, exp_rv;
        logic [15:0]  exp_addr;
        req = r;
        clear = c;
        #2;
        w = c ? -1 : pick(r, m_ptr, m_owner);
        exp_gnt  = (w >= 0) ? N'(1 << w) : '0;
        exp_addr = (w >= 0) ? addr[w*AW +: AW] : 16'h0;
        exp_rv   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        chk({tag, " gnt"}, gnt, exp_gnt);
        chk({tag, " im_read"}, im_read, (w >= 0));
        chk({tag, " im_addr"}, im_addr, exp_addr);
        chk({tag, " rvalid"}, rvalid, exp_rv);
        chk({tag, " rdata"}, rdata, m_rdata);
        chk({tag, " busy"}, busy, (m_owner >= 0));
        g_obs = gnt;
        @(posedge clk);
        if (c) begin
            m_owner = -1;
            m_ptr = 0;
        end else if (w >= 0) begin
            m_rdata = mem[exp_addr[7:0]];
            m_owner = w;
            m_ptr = (w + 1) % N;
        end else begin
            m_owner = -1;
        end
        @(negedge clk);
    endtask

    logic [N-1:0] g;
    logic [N-1:0] gseq [5];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h12] = 16'hA5A5;
        RESET_N = 1'b0;
        clear = 1'b0;
        req = 4'b1111;
        addr = '0;
        model_reset();

        // Reset held with all cores requesting.
        @(negedge clk);
        #2;
        chk("rst gnt", gnt, 4'b0000);
        chk("rst im_read", im_read, 1'b0);
        chk("rst rvalid", rvalid, 4'b0000);
        chk("rst rdata", rdata, 16'h0);
        chk("rst busy", busy, 1'b0);
        @(negedge clk);
        RESET_N = 1'b1;
        cycle(4'b1111, 1'b0, "post_rst", g);
        chk("post_rst first gnt", g, 4'b0001);

        // Single requester.
        cycle(4'b0000, 1'b1, "t2 clr", g);
        addr[2*AW +: AW] = 16'h0012;
        cycle(4'b0100, 1'b0, "t2 T", g);
        chk("t2 T gnt", g, 4'b0100);
        cycle(4'b0100, 1'b0, "t2 T1", g);
        chk("t2 T1 gnt", g, 4'b0000);
        chk("t2 T1 rdata", rdata, 16'hA5A5);
        cycle(4'b0100, 1'b0, "t2 T2", g);
        chk("t2 T2 gnt", g, 4'b0100);

        // Round robin over all cores from pointer 0.
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = 16'(16'h0100 + i * 3);
        cycle(4'b0000, 1'b1, "t3 clr", g);
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b0, "t3 rr", gseq[i]);
        chk("t3 seq0", gseq[0], 4'b0001);
        chk("t3 seq1", gseq[1], 4'b0010);
        chk("t3 seq2", gseq[2], 4'b0100);
        chk("t3 seq3", gseq[3], 4'b1000);
        chk("t3 seq4", gseq[4], 4'b0001);

        // Mask and wrap with two cores.
        cycle(4'b0000, 1'b1, "t4 clr", g);
        for (int i = 0; i < 4; i++) cycle(4'b1001, 1'b0, "t4 wrap", gseq[i]);
        chk("t4 seq0", gseq[0], 4'b0001);
        chk("t4 seq1", gseq[1], 4'b1000);
        chk("t4 seq2", gseq[2], 4'b0001);
        chk("t4 seq3", gseq[3], 4'b1000);

        // clear right after a grant to core 1.
        cycle(4'b0010, 1'b0, "t5 g1", g);
        chk("t5 g1 gnt", g, 4'b0010);
        cycle(4'b0011, 1'b1, "t5 clr", g);
        chk("t5 clr gnt", g, 4'b0000);
        cycle(4'b0011, 1'b0, "t5 after", g);
        chk("t5 after gnt", g, 4'b0001);

        // Asynchronous reset in the middle of a grant cycle.
        req = 4'b1000;
        clear = 1'b0;
        #2;
        chk("t6 gnt before rst", gnt, 4'b1000);
        RESET_N = 1'b0;
        #1;
        chk("t6 rvalid in rst", rvalid, 4'b0000);
        chk("t6 busy in rst", busy, 1'b0);
        chk("t6 gnt in rst", gnt, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        RESET_N = 1'b1;
        model_reset();
        cycle(4'b0000, 1'b0, "t6 idle", g);
        cycle(4'b1010, 1'b0, "t6 first", g);
        chk("t6 first gnt", g, 4'b0010);

        // Randomized traffic, occasional clear.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) addr[i*AW +: AW] = 16'($urandom);
            cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), "rand", g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
